// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, key-code map
// and the single-key detector used on debounced key maps.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LOCKED
  } kp_state_e;

  typedef struct packed {
    logic       one;
    logic       any;
    logic [3:0] idx;
  } onehot_t;

  // Map index is 4*col + row
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h4;
      4'd2:    code = 4'h7;
      4'd3:    code = 4'h0;
      4'd4:    code = 4'h2;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h8;
      4'd7:    code = 4'hF;
      4'd8:    code = 4'h3;
      4'd9:    code = 4'h6;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hE;
      4'd12:   code = 4'hA;
      4'd13:   code = 4'hB;
      4'd14:   code = 4'hC;
      4'd15:   code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic onehot_t onehot4x4(input logic [15:0] map);
    onehot_t    res;
    logic [4:0] cnt;
    cnt     = '0;
    res.idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (map[i]) begin
        cnt     = cnt + 5'd1;
        res.idx = 4'(i);
      end
    end
    res.one = (cnt == 5'd1);
    res.any = |map;
    return res;
  endfunction

endpackage

// File: rtl/Generic_counter.sv
// Free-running modulo counter 0..MAX with enable; wrap flags the enabled MAX cycle.
module Generic_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = en && (count == WIDTH'(MAX));

  always_ff @(posedge CLK) begin
    if (!RESET)  count <= '0;
    else if (en) count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a key map is accepted after DEBOUNCE_SCANS identical frames.
module keypad_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        frame_done,
  input  logic [15:0] frame_map,
  output logic [15:0] stable_map,
  output logic        stable_update
);

  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [CNT_W-1:0] MATCH_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [15:0]      candidate;
  logic [15:0]      stable_q;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] match_next;

  // stable_map already reflects the frame being accepted so the FSM can act on
  // the same edge that completes the frame.
  always_comb begin
    match_next = match_cnt;
    if (frame_map != candidate)  match_next = CNT_W'(1);
    else if (match_cnt != MATCH_MAX) match_next = match_cnt + 1'b1;
    stable_update = frame_done && (match_next == MATCH_MAX);
    stable_map    = stable_update ? frame_map : stable_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      candidate <= '0;
      match_cnt <= '0;
      stable_q  <= '0;
    end else if (frame_done) begin
      candidate <= frame_map;
      match_cnt <= match_next;
      if (stable_update) stable_q <= frame_map;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, row sampling, debounce and
// single-key reporting into a four-digit history for the display driver.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  ROW_IN,
  output logic [3:0]  COL_OUT,
  output logic [3:0]  KEY_CODE,
  output logic        KEY_VALID,
  output logic        KEY_HELD,
  output logic [15:0] VALUE_OUT
);

  localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

  logic [3:0]        row_p0, row_p1;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [1:0]        col;
  logic              frame_done;
  logic [15:0]       raw_map;
  logic [15:0]       frame_map;
  logic [15:0]       stable_map;
  logic              stable_update;
  kp_state_e         state, state_next;
  logic [3:0]        key_idx, idx_next;
  logic              valid_next;
  onehot_t           oh;

  // Stage p0/p1: two-flop synchroniser for the asynchronous rows
  always_ff @(posedge CLK) begin
    row_p0 <= ROW_IN;
    row_p1 <= row_p0;
  end

  Generic_counter #(.WIDTH(TICK_W), .MAX(SCAN_TICKS - 1)) u_tick_cnt (
    .CLK(CLK), .RESET(RESET), .en(1'b1), .count(tick_cnt), .wrap(tick)
  );

  // Column counter wraps on the tick that samples column 3, i.e. frame completion
  Generic_counter #(.WIDTH(2), .MAX(3)) u_col_cnt (
    .CLK(CLK), .RESET(RESET), .en(tick), .count(col), .wrap(frame_done)
  );

  assign COL_OUT = ~(4'b0001 << col);

  always_ff @(posedge CLK) begin
    if (!RESET)    raw_map <= '0;
    else if (tick) raw_map[{col, 2'b00} +: 4] <= ~row_p1;
  end

  // Column 3 is captured on the same edge, so the completed frame is merged here
  assign frame_map = {~row_p1, raw_map[11:0]};

  keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .CLK(CLK), .RESET(RESET), .frame_done(frame_done), .frame_map(frame_map),
    .stable_map(stable_map), .stable_update(stable_update)
  );

  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    idx_next   = key_idx;
    oh         = onehot4x4(stable_map);
    if (stable_update) begin
      unique case (state)
        ST_IDLE: begin
          if (oh.one) begin
            state_next = ST_PRESSED;
            valid_next = 1'b1;
            idx_next   = oh.idx;
          end else if (oh.any) begin
            state_next = ST_LOCKED;
          end
        end
        ST_PRESSED: begin
          if (!oh.any)                              state_next = ST_IDLE;
          else if (!(oh.one && oh.idx == key_idx))  state_next = ST_LOCKED;
        end
        ST_LOCKED: if (!oh.any) state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      key_idx   <= '0;
      KEY_VALID <= 1'b0;
      KEY_CODE  <= '0;
      VALUE_OUT <= '0;
    end else begin
      state     <= state_next;
      key_idx   <= idx_next;
      KEY_VALID <= valid_next;
      if (valid_next) begin
        KEY_CODE  <= key_code(idx_next);
        VALUE_OUT <= {VALUE_OUT[11:0], key_code(idx_next)};
      end
    end
  end

  assign KEY_HELD = (state == ST_PRESSED);

endmodule
